// File: rtl/countdown_pkg.sv
// Shared encodings for the hh:mm:ss countdown timer.
// Used by the sequencing controller and the counter top level.
package countdown_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        ALARM = ST_ALARM
    } state_t;

    localparam logic [23:0] ZERO_VALUE = 24'h000000;

endpackage

// File: rtl/countdown_ctrl.sv
// Countdown sequencing FSM: run/pause/clear protocol, zero detect,
// counter enable gating, reload pulse and timed alarm.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int ALARM_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic [23:0] cnt_value,
    output logic        cnt_en,
    output logic        cnt_load_n,
    output logic [1:0]  state,
    output logic        running,
    output logic        paused,
    output logic        alarm
);

    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
    localparam logic [AW-1:0] ALARM_MAX  = AW'(ALARM_TICKS);

    state_t        st;
    state_t        nxt;
    logic          reload;
    logic          zero;
    logic [AW-1:0] alarm_cnt;

    assign zero   = (cnt_value == ZERO_VALUE);
    assign state  = st;
    // Gated combinationally so the chain can never borrow below zero.
    assign cnt_en = (st == RUN) & tick & ~zero;

    always_comb begin
        nxt    = st;
        reload = 1'b0;
        unique case (st)
            IDLE: begin
                if (clear)
                    reload = 1'b1;
                else if (start_stop)
                    nxt = zero ? ALARM : RUN;
            end
            RUN: begin
                if (clear) begin
                    nxt    = IDLE;
                    reload = 1'b1;
                end else if (zero)
                    nxt = ALARM;
                else if (start_stop)
                    nxt = PAUSE;
            end
            PAUSE: begin
                if (clear) begin
                    nxt    = IDLE;
                    reload = 1'b1;
                end else if (start_stop)
                    nxt = RUN;
            end
            ALARM: begin
                if (clear || start_stop ||
                    (tick && alarm_cnt >= ALARM_LAST)) begin
                    nxt    = IDLE;
                    reload = 1'b1;
                end
            end
            default: begin
                nxt    = IDLE;
                reload = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            running    <= 1'b0;
            paused     <= 1'b0;
            alarm      <= 1'b0;
            cnt_load_n <= 1'b0;
            alarm_cnt  <= '0;
        end else begin
            st         <= nxt;
            running    <= (nxt == RUN);
            paused     <= (nxt == PAUSE);
            alarm      <= (nxt == ALARM);
            cnt_load_n <= ~reload;
            if (nxt == ALARM && st != ALARM)
                alarm_cnt <= '0;
            else if (st == ALARM && tick && alarm_cnt != ALARM_MAX)
                alarm_cnt <= alarm_cnt + AW'(1);
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a behavioural BCD
// down-counter closing the loop on cnt_value.
module tb_countdown_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        start_stop;
    logic        clear;
    logic [23:0] cnt_value;
    logic        cnt_en;
    logic        cnt_load_n;
    logic [1:0]  state;
    logic        running;
    logic        paused;
    logic        alarm;

    logic [23:0] init_val;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          en_count = 0;
    logic        en_seen;

    countdown_ctrl #(.ALARM_TICKS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .cnt_value  (cnt_value),
        .cnt_en     (cnt_en),
        .cnt_load_n (cnt_load_n),
        .state      (state),
        .running    (running),
        .paused     (paused),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        done;
        r    = v;
        done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!done) begin
                if (r[4*i +: 4] == 4'd0)
                    r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    done = 1'b1;
                end
            end
        end
        return r;
    endfunction

    initial cnt_value = 24'h0;
    always @(posedge clk) begin
        if (!cnt_load_n)
            cnt_value <= init_val;
        else if (cnt_en)
            cnt_value <= bcd_dec(cnt_value);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic ss, input logic clr, input logic tk);
        @(negedge clk);
        start_stop = ss;
        clear      = clr;
        tick       = tk;
        #1;
        en_seen = cnt_en;
        if (cnt_en) en_count++;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        tick       = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        tick       = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        init_val   = 24'h000003;

        // reset and load release
        repeat (3) @(posedge clk);
        #1;
        check("rst_load_n", 32'(cnt_load_n), 0);
        check("rst_state", 32'(state), 0);
        check("rst_flags", {29'd0, running, paused, alarm}, 0);
        check("rst_en", 32'(cnt_en), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_load_n_low", 32'(cnt_load_n), 0);
        @(posedge clk);
        #1;
        check("rel_load_n_high", 32'(cnt_load_n), 1);
        check("rel_value", 32'(cnt_value), 32'h3);

        // basic countdown into alarm
        en_count = 0;
        step(1, 0, 0);
        check("start_state", 32'(state), 1);
        check("start_running", 32'(running), 1);
        repeat (3) step(0, 0, 1);
        check("cd_en_count", en_count, 3);
        check("cd_value", 32'(cnt_value), 0);
        check("cd_still_run", 32'(state), 1);
        step(0, 0, 0);
        check("zero_alarm", 32'(alarm), 1);
        check("zero_state", 32'(state), 3);
        step(0, 0, 1);
        check("alarm_tick1", 32'(state), 3);
        step(0, 0, 1);
        check("alarm_done_state", 32'(state), 0);
        check("alarm_done_flag", 32'(alarm), 0);
        check("alarm_done_load", 32'(cnt_load_n), 0);
        step(0, 0, 0);
        check("alarm_reload_hi", 32'(cnt_load_n), 1);
        check("alarm_reload_val", 32'(cnt_value), 32'h3);
        check("alarm_en_total", en_count, 3);

        // pause sequence
        init_val = 24'h000010;
        step(0, 1, 0);
        check("idle_clear_load", 32'(cnt_load_n), 0);
        check("idle_clear_state", 32'(state), 0);
        step(0, 0, 0);
        check("idle_clear_val", 32'(cnt_value), 32'h10);
        step(1, 0, 0);
        repeat (4) step(0, 0, 1);
        check("p_run4_val", 32'(cnt_value), 32'h6);
        step(1, 0, 0);
        check("p_state", 32'(state), 2);
        check("p_flag", 32'(paused), 1);
        en_count = 0;
        repeat (5) step(0, 0, 1);
        check("p_no_en", en_count, 0);
        check("p_hold_val", 32'(cnt_value), 32'h6);
        step(1, 0, 0);
        check("p_resume", 32'(state), 1);
        repeat (2) step(0, 0, 1);
        check("p_final_val", 32'(cnt_value), 32'h4);

        // simultaneous events
        step(1, 0, 1);
        check("ss_tick_en", 32'(en_seen), 1);
        check("ss_tick_val", 32'(cnt_value), 32'h3);
        check("ss_tick_state", 32'(state), 2);
        step(1, 1, 0);
        check("clr_ss_state", 32'(state), 0);
        check("clr_ss_load", 32'(cnt_load_n), 0);
        step(0, 0, 0);
        check("clr_ss_val", 32'(cnt_value), 32'h10);

        // zero init
        init_val = 24'h000000;
        step(0, 1, 0);
        step(0, 0, 0);
        check("z_val", 32'(cnt_value), 0);
        en_count = 0;
        step(1, 0, 0);
        check("z_alarm_state", 32'(state), 3);
        check("z_alarm_flag", 32'(alarm), 1);
        step(0, 0, 0);
        step(0, 1, 0);
        check("z_clear_state", 32'(state), 0);
        check("z_clear_load", 32'(cnt_load_n), 0);
        check("z_no_en", en_count, 0);

        // asynchronous reset during run
        init_val = 24'h000002;
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("mr_run", 32'(state), 1);
        check("mr_val", 32'(cnt_value), 32'h2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mr_state", 32'(state), 0);
        check("mr_running", 32'(running), 0);
        check("mr_alarm", 32'(alarm), 0);
        check("mr_load", 32'(cnt_load_n), 0);

        // asynchronous reset during alarm
        init_val = 24'h000000;
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0);
        step(1, 0, 0);
        check("ma_alarm_set", 32'(alarm), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ma_alarm_clr", 32'(alarm), 0);
        check("ma_state", 32'(state), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
